// File: rtl/maxpool_stream.sv
// Streaming ReLU max-pool: emits the max of each WINDOW-sample window (or a flushed partial window).
// Optional MAXPOOL_ARGMAX_EN adds out_index, the earliest position of the maximum within the window.
module maxpool_stream #(
  parameter int DATA_W = 8,
  parameter int WINDOW = 4,
  parameter int CNT_W  = $clog2(WINDOW + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  out_count
`ifdef MAXPOOL_ARGMAX_EN
  ,
  output logic [CNT_W-1:0]  out_index
`endif
);

  logic [DATA_W-1:0] acc, acc_nxt, sample;
  logic [CNT_W-1:0]  count, cnt_nxt;
  logic              accept, close;
`ifdef MAXPOOL_ARGMAX_EN
  logic [CNT_W-1:0]  idx, idx_nxt;
`endif

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  // acc_nxt/cnt_nxt already include this cycle's sample, so a closing window loads them directly.
  always_comb begin
    sample  = in_data[DATA_W-1] ? '0 : in_data;
    acc_nxt = acc;
    cnt_nxt = count;
`ifdef MAXPOOL_ARGMAX_EN
    idx_nxt = idx;
`endif
    if (accept) begin
      cnt_nxt = count + CNT_W'(1);
      if (sample > acc) begin
        acc_nxt = sample;
`ifdef MAXPOOL_ARGMAX_EN
        idx_nxt = count;
`endif
      end
    end
    close = (accept && (cnt_nxt == CNT_W'(WINDOW))) ||
            (in_flush && in_ready && (cnt_nxt != '0));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc       <= '0;
      count     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_count <= '0;
`ifdef MAXPOOL_ARGMAX_EN
      idx       <= '0;
      out_index <= '0;
`endif
    end else if (close) begin
      out_valid <= 1'b1;
      out_data  <= acc_nxt;
      out_count <= cnt_nxt;
      acc       <= '0;
      count     <= '0;
`ifdef MAXPOOL_ARGMAX_EN
      idx       <= '0;
      out_index <= idx_nxt;
`endif
    end else begin
      acc   <= acc_nxt;
      count <= cnt_nxt;
`ifdef MAXPOOL_ARGMAX_EN
      idx   <= idx_nxt;
`endif
      if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_maxpool_stream.sv
// Bench for maxpool_stream: window-list reference model checked every cycle, plus directed literal results.
module tb_maxpool_stream;

  localparam int DATA_W = 8;
  localparam int WINDOW = 4;
  localparam int CNT_W  = 3;

  logic              clk = 1'b0;
  logic              rst, in_valid, in_flush, out_ready;
  logic [DATA_W-1:0] in_data;
  logic              in_ready, out_valid;
  logic [DATA_W-1:0] out_data;
  logic [CNT_W-1:0]  out_count;
`ifdef MAXPOOL_ARGMAX_EN
  logic [CNT_W-1:0]  out_index;
`endif

  maxpool_stream #(.DATA_W(DATA_W), .WINDOW(WINDOW), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_flush(in_flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_count(out_count)
`ifdef MAXPOOL_ARGMAX_EN
    , .out_index(out_index)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: list of clamped samples in the open window plus the held result.
  int   win[$];
  bit   m_known = 0;
  bit   m_ov = 0;
  int   m_od = 0, m_oc = 0, m_oi = 0;

  function automatic int clampv(input logic [DATA_W-1:0] x);
    return x[DATA_W-1] ? 0 : int'(x);
  endfunction

  always @(negedge clk) begin
    bit exp_rdy, acc, cls;
    int best, bidx;
    exp_rdy = !m_ov || out_ready;
    if (m_known) begin
      check("in_ready", 32'(in_ready), 32'(exp_rdy));
      check("out_valid", 32'(out_valid), 32'(m_ov));
      if (m_ov) begin
        check("out_data", 32'(out_data), 32'(m_od));
        check("out_count", 32'(out_count), 32'(m_oc));
`ifdef MAXPOOL_ARGMAX_EN
        check("out_index", 32'(out_index), 32'(m_oi));
`endif
      end
    end
    if (rst) begin
      m_known = 1;
      win.delete();
      m_ov = 0; m_od = 0; m_oc = 0; m_oi = 0;
    end else if (m_known) begin
      acc = in_valid && exp_rdy;
      if (acc) win.push_back(clampv(in_data));
      cls = (acc && win.size() == WINDOW) || (in_flush && exp_rdy && win.size() > 0);
      if (cls) begin
        best = -1; bidx = 0;
        foreach (win[k]) if (win[k] > best) begin best = win[k]; bidx = k; end
        m_ov = 1; m_od = best; m_oc = win.size(); m_oi = bidx;
        win.delete();
      end else if (m_ov && out_ready) begin
        m_ov = 0;
      end
    end
  end

  // Log every consumed result for the literal checks.
  typedef struct { int d; int c; int i; } res_t;
  res_t got_q[$];

  always @(negedge clk) begin
    res_t r;
    if (!rst && out_valid === 1'b1 && out_ready === 1'b1) begin
      r.d = int'(out_data);
      r.c = int'(out_count);
`ifdef MAXPOOL_ARGMAX_EN
      r.i = int'(out_index);
`else
      r.i = 0;
`endif
      got_q.push_back(r);
    end
  end

  task automatic push(input logic [7:0] d, input logic v, input logic f);
    logic took;
    took = 1'b0;
    in_data = d; in_valid = v; in_flush = f;
    for (int t = 0; t < 40 && !took; t++) begin
      @(negedge clk); took = in_ready;
      @(posedge clk); #1;
    end
    if (!took) check("push_timeout", 32'(took), 32'd1);
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0; in_flush = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic expect_res(input string nm, input int d, input int c, input int i);
    res_t r;
    if (got_q.size() == 0) begin
      check({nm, "_present"}, 32'd0, 32'd1);
    end else begin
      r = got_q.pop_front();
      check({nm, "_data"}, 32'(r.d), 32'(d));
      check({nm, "_count"}, 32'(r.c), 32'(c));
`ifdef MAXPOOL_ARGMAX_EN
      check({nm, "_index"}, 32'(r.i), 32'(i));
`else
      if (i < 0) check({nm, "_index"}, 32'(r.i), 32'd0);
`endif
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    rst = 1'b1; in_valid = 1'b0; in_flush = 1'b0; in_data = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_out_count", 32'(out_count), 32'd0);
    @(posedge clk); #1;

    // Basic window, back-to-back accepts
    push(8'h05, 1, 0); push(8'h83, 1, 0); push(8'h12, 1, 0); push(8'h7F, 1, 0);
    in_valid = 1'b0;
    check("basic_latency_valid", 32'(out_valid), 32'd1);
    check("basic_latency_data", 32'(out_data), 32'h7F);
    idle(3);
    expect_res("basic", 'h7F, 4, 3);

    // All negative, including -0
    push(8'h81, 1, 0); push(8'hFF, 1, 0); push(8'h80, 1, 0); push(8'h90, 1, 0);
    idle(3);
    expect_res("allneg", 0, 4, 0);

    // Backpressure: result held while window 2 is offered
    out_ready = 1'b0;
    push(8'h10, 1, 0); push(8'h20, 1, 0); push(8'h30, 1, 0); push(8'h40, 1, 0);
    fork
      begin
        push(8'h50, 1, 0); push(8'h01, 1, 0); push(8'h02, 1, 0); push(8'h03, 1, 0);
      end
      begin
        repeat (5) begin
          @(negedge clk);
          check("bp_in_ready", 32'(in_ready), 32'd0);
          check("bp_hold_data", 32'(out_data), 32'h40);
        end
        @(posedge clk); #1 out_ready = 1'b1;
      end
    join
    idle(3);
    check("bp_results", 32'(got_q.size()), 32'd2);
    expect_res("bp_first", 'h40, 4, 3);
    expect_res("bp_second", 'h50, 4, 0);

    // Flush a partial window
    push(8'h10, 1, 0); push(8'h20, 1, 0); push(8'h00, 0, 1);
    idle(3);
    expect_res("flush_partial", 'h20, 2, 1);

    // Flush on an empty window produces nothing
    n0 = got_q.size();
    push(8'h00, 0, 1);
    idle(4);
    check("flush_empty_none", 32'(got_q.size()), 32'(n0));

    // Flush coinciding with an accept
    push(8'h10, 1, 0); push(8'h33, 1, 1);
    idle(3);
    expect_res("flush_accept", 'h33, 2, 1);

    // Reset mid-window discards the partial window
    push(8'h70, 1, 0); push(8'h60, 1, 0);
    in_valid = 1'b0; rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    n0 = got_q.size();
    push(8'h01, 1, 0); push(8'h02, 1, 0); push(8'h03, 1, 0); push(8'h04, 1, 0);
    idle(3);
    check("rst_mid_results", 32'(got_q.size()), 32'(n0 + 1));
    expect_res("rst_mid", 'h04, 4, 3);

`ifdef MAXPOOL_ARGMAX_EN
    // Tie keeps the earliest maximum
    push(8'h30, 1, 0); push(8'h40, 1, 0); push(8'h40, 1, 0); push(8'h10, 1, 0);
    idle(3);
    expect_res("argmax", 'h40, 4, 1);
`endif

    idle(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
